// File: rtl/voice_cmd_matcher.sv
// Voice-command matcher: records CHUNKS packed PDM words, scores them against N_DIRS templates, reports the best direction.
// Optional MATCH_MARGIN_EN: the winner must also lead the runner-up by at least MARGIN.
module voice_cmd_matcher #(
   parameter int N_DIRS      = 4,
   parameter int CHUNKS      = 2830,
   parameter int SAMPLE_W    = 8,
   parameter int ADDR_W      = 12,
   parameter int THRESH      = 15,
   parameter int DEFAULT_DIR = 1,
   parameter int MARGIN      = 64,
   localparam int DIR_W      = $clog2(N_DIRS),
   localparam int SCORE_W    = $clog2(4*CHUNKS+1),
   localparam int WORD_W     = 4*SAMPLE_W
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_enable,
   input  logic                     i_compare_en,
   input  logic                     i_sample_valid,
   input  logic [WORD_W-1:0]        i_sample_data,
   output logic                     o_sample_req,
   output logic                     o_rec_wr,
   output logic [ADDR_W-1:0]        o_rec_addr,
   output logic [WORD_W-1:0]        o_rec_wdata,
   input  logic [WORD_W-1:0]        i_rec_rdata,
   output logic [ADDR_W-1:0]        o_tmpl_addr,
   input  logic [N_DIRS*WORD_W-1:0] i_tmpl_rdata,
   output logic                     o_busy,
   output logic [DIR_W-1:0]         o_match,
   output logic                     o_match_valid
);

`ifdef MATCH_MARGIN_EN
   localparam bit MARGIN_EN = 1'b1;
`else
   localparam bit MARGIN_EN = 1'b0;
`endif

   localparam logic [ADDR_W:0]    C_CHUNKS  = (ADDR_W+1)'(CHUNKS);
   localparam logic [ADDR_W:0]    C_LAST    = (ADDR_W+1)'(CHUNKS-1);
   localparam logic [ADDR_W:0]    C_ONE     = (ADDR_W+1)'(1);
   localparam logic [SAMPLE_W:0]  C_THRESH  = (SAMPLE_W+1)'(THRESH);
   localparam logic [DIR_W-1:0]   C_DEFAULT = DIR_W'(DEFAULT_DIR);
   localparam logic [SCORE_W:0]   C_MARGIN  = (SCORE_W+1)'(MARGIN);

   typedef enum logic [1:0] {S_IDLE, S_RECORD, S_COMPARE, S_DECIDE} state_t;

   state_t               r_state;
   // One bit wider than the RAM address so the drain cycle can sit at CHUNKS.
   logic [ADDR_W:0]      r_addr;
   logic                 r_rd_valid;
   logic [SCORE_W-1:0]   r_score [N_DIRS];
   logic [DIR_W-1:0]     r_match;
   logic                 r_match_valid;

   logic                 w_in_range;
   logic                 w_wr;
   logic [2:0]           w_hits [N_DIRS];
   logic [SAMPLE_W:0]    w_a, w_b, w_diff;
   logic                 w_found, w_beats, w_margin_ok, w_ok;
   logic [DIR_W-1:0]     w_win;
   logic [SCORE_W-1:0]   w_second;

   assign w_in_range    = (r_addr < C_CHUNKS);
   assign o_sample_req  = (r_state == S_RECORD) && w_in_range;
   assign w_wr          = o_sample_req && i_enable && i_sample_valid;
   assign o_rec_wr      = w_wr;
   assign o_rec_addr    = r_addr[ADDR_W-1:0];
   assign o_tmpl_addr   = r_addr[ADDR_W-1:0];
   assign o_rec_wdata   = i_sample_data;
   assign o_busy        = (r_state != S_IDLE);
   assign o_match       = r_match;
   assign o_match_valid = r_match_valid;

   always_comb begin
      w_a = '0;
      w_b = '0;
      w_diff = '0;
      for (int d = 0; d < N_DIRS; d++) begin
         w_hits[d] = '0;
         for (int j = 0; j < 4; j++) begin
            w_a    = {1'b0, i_rec_rdata[j*SAMPLE_W +: SAMPLE_W]};
            w_b    = {1'b0, i_tmpl_rdata[d*WORD_W + j*SAMPLE_W +: SAMPLE_W]};
            w_diff = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
            if (w_diff <= C_THRESH)
               w_hits[d] = w_hits[d] + 3'd1;
         end
      end
   end

   always_comb begin
      w_found  = 1'b0;
      w_beats  = 1'b0;
      w_win    = C_DEFAULT;
      w_second = '0;
      for (int d = 0; d < N_DIRS; d++) begin
         w_beats = 1'b1;
         for (int e = 0; e < N_DIRS; e++)
            if (e != d && r_score[d] <= r_score[e])
               w_beats = 1'b0;
         if (w_beats) begin
            w_found = 1'b1;
            w_win   = DIR_W'(d);
         end
      end
      for (int e = 0; e < N_DIRS; e++)
         if (DIR_W'(e) != w_win && r_score[e] > w_second)
            w_second = r_score[e];
      w_margin_ok = ({1'b0, r_score[w_win]} >= ({1'b0, w_second} + C_MARGIN));
      w_ok        = w_found && (!MARGIN_EN || w_margin_ok);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state       <= S_IDLE;
         r_addr        <= '0;
         r_rd_valid    <= 1'b0;
         r_match       <= C_DEFAULT;
         r_match_valid <= 1'b0;
         for (int d = 0; d < N_DIRS; d++)
            r_score[d] <= '0;
      end else begin
         r_match_valid <= 1'b0;
         r_rd_valid    <= 1'b0;
         if (r_rd_valid)
            for (int d = 0; d < N_DIRS; d++)
               r_score[d] <= r_score[d] + SCORE_W'(w_hits[d]);
         case (r_state)
            S_IDLE: begin
               r_addr <= '0;
               for (int d = 0; d < N_DIRS; d++)
                  r_score[d] <= '0;
               if (i_enable)
                  r_state <= S_RECORD;
            end
            S_RECORD: begin
               if (!i_enable) begin
                  r_addr  <= '0;
                  r_state <= S_IDLE;
               end else if (w_wr) begin
                  if (r_addr == C_LAST) begin
                     r_addr  <= '0;
                     r_state <= i_compare_en ? S_COMPARE : S_IDLE;
                  end else begin
                     r_addr <= r_addr + C_ONE;
                  end
               end
            end
            S_COMPARE: begin
               // Read data returns one cycle after the address; the extra cycle drains the last word.
               if (w_in_range) begin
                  r_rd_valid <= 1'b1;
                  r_addr     <= r_addr + C_ONE;
               end else begin
                  r_addr  <= '0;
                  r_state <= S_DECIDE;
               end
            end
            S_DECIDE: begin
               r_match       <= w_ok ? w_win : C_DEFAULT;
               r_match_valid <= 1'b1;
               r_state       <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_voice_cmd_matcher.sv
// Scoreboard bench for voice_cmd_matcher with CHUNKS=8, N_DIRS=4, behavioural record/template RAMs.
module tb_voice_cmd_matcher;

   localparam int N_DIRS = 4;
   localparam int CHUNKS = 8;
   localparam int SW     = 8;
   localparam int AW     = 3;
   localparam int WW     = 4*SW;
   localparam int DW     = 2;
   localparam int LAT    = CHUNKS + 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_en, in_cmp, in_sv;
   logic [WW-1:0]     in_sd;
   logic              o_sample_req, o_rec_wr, o_busy, o_match_valid;
   logic [AW-1:0]     o_rec_addr, o_tmpl_addr;
   logic [WW-1:0]     o_rec_wdata;
   logic [WW-1:0]     rec_rdata;
   logic [N_DIRS*WW-1:0] tmpl_rdata;
   logic [DW-1:0]     o_match;

   logic [WW-1:0]     rec_mem  [CHUNKS];
   logic [WW-1:0]     tmpl_mem [N_DIRS][CHUNKS];
   logic [WW-1:0]     rec_words[CHUNKS];

   typedef struct { int m; int c; } exp_t;
   exp_t sb_q[$];

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int wr_cnt = 0;

   always #5 clk = ~clk;

   voice_cmd_matcher #(
      .N_DIRS(N_DIRS), .CHUNKS(CHUNKS), .SAMPLE_W(SW), .ADDR_W(AW),
      .THRESH(15), .DEFAULT_DIR(1), .MARGIN(64)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_enable(in_en), .i_compare_en(in_cmp),
      .i_sample_valid(in_sv), .i_sample_data(in_sd), .o_sample_req(o_sample_req),
      .o_rec_wr(o_rec_wr), .o_rec_addr(o_rec_addr), .o_rec_wdata(o_rec_wdata),
      .i_rec_rdata(rec_rdata), .o_tmpl_addr(o_tmpl_addr), .i_tmpl_rdata(tmpl_rdata),
      .o_busy(o_busy), .o_match(o_match), .o_match_valid(o_match_valid)
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (o_rec_wr) rec_mem[o_rec_addr] <= o_rec_wdata;
      rec_rdata <= rec_mem[o_rec_addr];
      for (int d = 0; d < N_DIRS; d++)
         tmpl_rdata[d*WW +: WW] <= tmpl_mem[d][o_tmpl_addr];
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every match_valid pulse must line up with a scoreboard entry.
   always @(negedge clk) begin
      if (o_rec_wr) wr_cnt++;
      if (o_match_valid) begin
         if (sb_q.size() == 0) begin
            check("unexpected_match_valid", 1, 0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("match", int'(o_match), e.m);
            check("match_latency", cyc, e.c);
         end
      end
   end

   task automatic set_tmpl(input int d, input logic [WW-1:0] w);
      for (int i = 0; i < CHUNKS; i++) tmpl_mem[d][i] = w;
   endtask

   task automatic set_rec(input logic [WW-1:0] w);
      for (int i = 0; i < CHUNKS; i++) rec_words[i] = w;
   endtask

   // Called at a negedge in IDLE. exp_m < 0 means no match pulse is expected.
   task automatic do_record(input int n, input bit cmp, input bit abort, input int exp_m);
      in_en = 1'b1;
      in_cmp = cmp;
      @(posedge clk); @(negedge clk);
      check("sample_req_in_record", int'(o_sample_req), 1);
      for (int i = 0; i < n; i++) begin
         in_sv = 1'b1;
         in_sd = rec_words[i];
         #1;
         check("rec_wr_strobe", int'(o_rec_wr), 1);
         check("rec_addr", int'(o_rec_addr), i);
         check("rec_wdata", int'(o_rec_wdata == rec_words[i]), 1);
         @(posedge clk); @(negedge clk);
      end
      in_sv = 1'b0;
      if (abort) begin
         in_en = 1'b0;
         in_sv = 1'b1;
         #1;
         check("no_write_on_abort", int'(o_rec_wr), 0);
         @(posedge clk); @(negedge clk);
         in_sv = 1'b0;
         check("idle_after_abort", int'(o_busy), 0);
      end else begin
         in_en = 1'b0;
         if (exp_m >= 0) begin
            exp_t e;
            e.m = exp_m;
            e.c = cyc + LAT;
            sb_q.push_back(e);
         end
      end
   endtask

   task automatic wait_done();
      bit done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk);
         if (sb_q.size() == 0 && !o_busy) done = 1'b1;
      end
      check("completion_timeout", int'(done), 1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int wr0;
      int exp_margin;
      rst_n = 1'b0; in_en = 1'b0; in_cmp = 1'b0; in_sv = 1'b0; in_sd = '0;
      for (int i = 0; i < CHUNKS; i++) rec_mem[i] = '0;
      for (int d = 0; d < N_DIRS; d++) set_tmpl(d, 32'h8080_8080);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_busy", int'(o_busy), 0);
      check("reset_match", int'(o_match), 1);
      check("reset_match_valid", int'(o_match_valid), 0);
      check("reset_sample_req", int'(o_sample_req), 0);
      check("reset_rec_wr", int'(o_rec_wr), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Only template 2 matches the recording.
      set_rec(32'h1010_1010);
      set_tmpl(2, 32'h1010_1010);
      do_record(CHUNKS, 1'b1, 1'b0, 2);
      wait_done();

      // Reset mid-compare abandons the operation.
      do_record(CHUNKS, 1'b1, 1'b0, -1);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("midrst_busy", int'(o_busy), 0);
      check("midrst_match", int'(o_match), 1);
      check("midrst_match_valid", int'(o_match_valid), 0);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);

      // Tie between templates 0 and 3 falls back to the default direction.
      set_tmpl(2, 32'h8080_8080);
      set_tmpl(0, 32'h1010_1010);
      set_tmpl(3, 32'h1010_1010);
      do_record(CHUNKS, 1'b1, 1'b0, 1);
      wait_done();

      // Unique winner at the highest index.
      set_tmpl(0, 32'h8080_8080);
      do_record(CHUNKS, 1'b1, 1'b0, 3);
      wait_done();

      // Threshold edge: diff 15 in every lane hits, diff 16 / 255 miss.
      set_rec(32'hFF00_FF00);
      set_tmpl(0, 32'hF00F_F00F);
      set_tmpl(1, 32'hEF10_EF10);
      set_tmpl(2, 32'h00FF_00FF);
      set_tmpl(3, 32'h7F80_7F80);
      do_record(CHUNKS, 1'b1, 1'b0, 0);
      wait_done();

      // Abort after 3 words.
      set_rec(32'h1234_5678);
      wr0 = wr_cnt;
      do_record(3, 1'b1, 1'b1, -1);
      repeat (15) @(negedge clk);
      check("abort_write_count", wr_cnt - wr0, 3);
      check("abort_busy", int'(o_busy), 0);

      // Record only: eight writes, no match.
      wr0 = wr_cnt;
      do_record(CHUNKS, 1'b0, 1'b0, -1);
      @(negedge clk);
      check("rec_only_busy", int'(o_busy), 0);
      repeat (15) @(negedge clk);
      check("rec_only_write_count", wr_cnt - wr0, CHUNKS);

      // Scores 32/0/28/0: leader wins only if no margin is demanded.
      set_rec(32'h1010_1010);
      set_tmpl(0, 32'h1010_1010);
      set_tmpl(1, 32'h8080_8080);
      set_tmpl(2, 32'h1010_1010);
      tmpl_mem[2][CHUNKS-1] = 32'h8080_8080;
      set_tmpl(3, 32'h8080_8080);
`ifdef MATCH_MARGIN_EN
      exp_margin = 1;
`else
      exp_margin = 0;
`endif
      do_record(CHUNKS, 1'b1, 1'b0, exp_margin);
      wait_done();

      check("scoreboard_drained", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
